// File: rtl/uart_regs_pkg.sv
// Shared constants for the UART register file: address map, IIR codes,
// register bit positions and the RX trigger-level helper.
package uart_regs_pkg;

    localparam logic [2:0] A_RB  = 3'd0;
    localparam logic [2:0] A_IER = 3'd1;
    localparam logic [2:0] A_IIR = 3'd2;
    localparam logic [2:0] A_LCR = 3'd3;
    localparam logic [2:0] A_MCR = 3'd4;
    localparam logic [2:0] A_LSR = 3'd5;
    localparam logic [2:0] A_MSR = 3'd6;
    localparam logic [2:0] A_SCR = 3'd7;

    localparam logic [3:0] IIR_RLS  = 4'b0110;
    localparam logic [3:0] IIR_RDA  = 4'b0100;
    localparam logic [3:0] IIR_TI   = 4'b1100;
    localparam logic [3:0] IIR_THRE = 4'b0010;
    localparam logic [3:0] IIR_MS   = 4'b0000;
    localparam logic [3:0] IIR_NONE = 4'b0001;

    localparam int LCR_DLAB = 7;

    localparam int IER_RDA  = 0;
    localparam int IER_THRE = 1;
    localparam int IER_RLS  = 2;
    localparam int IER_MS   = 3;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_PE   = 2;
    localparam int LSR_FE   = 3;
    localparam int LSR_BI   = 4;
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;
    localparam int LSR_ERR  = 7;

    localparam int MSR_CTS  = 4;
    localparam int MSR_DSR  = 5;
    localparam int MSR_RI   = 6;
    localparam int MSR_DCD  = 7;

    localparam int MCR_LOOP = 4;

    function automatic int unsigned rx_trigger(input logic [1:0] sel,
                                               input int unsigned depth);
        case (sel)
            2'b00:   return 1;
            2'b01:   return depth / 4;
            2'b10:   return depth / 2;
            default: return depth - 2;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// x16 baud enable generator: down-counter on DL with an optional
// fractional accumulator (UART_FRAC_DIV_EN) that stretches periods by one.
module uart_baud_gen
    import uart_regs_pkg::*;
#(
    parameter int DL_W = 16
) (
    input  logic            clk,
    input  logic            rst,
`ifdef UART_FRAC_DIV_EN
    input  logic [3:0]      dlf,
`endif
    input  logic [DL_W-1:0] dl,
    input  logic            reload,
    output logic            enable
);

    logic [DL_W-1:0] dlc;
    logic [DL_W-1:0] dl_m1;
    logic            term;

    assign term   = (dlc == '0) && (dl != '0);
    assign enable = term;
    assign dl_m1  = (dl == '0) ? '0 : dl - DL_W'(1);

`ifdef UART_FRAC_DIV_EN
    logic [3:0] acc;
    logic [4:0] sum;

    assign sum = {1'b0, acc} + {1'b0, dlf};

    // A carry out of the accumulator loads DL instead of DL-1,
    // adding one idle cycle to the next period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dlc <= '0;
            acc <= '0;
        end else if (reload) begin
            dlc <= dl_m1;
            acc <= '0;
        end else if (term) begin
            acc <= sum[3:0];
            dlc <= sum[4] ? dl : dl_m1;
        end else if (dlc != '0) begin
            dlc <= dlc - DL_W'(1);
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dlc <= '0;
        end else if (reload || term) begin
            dlc <= dl_m1;
        end else if (dlc != '0) begin
            dlc <= dlc - DL_W'(1);
        end
    end
`endif

endmodule

// File: rtl/uart_regs_gen.sv
// 16550-style register file, baud generator and interrupt prioritiser.
// Optional fractional divisor enabled by defining UART_FRAC_DIV_EN.
module uart_regs_gen
    import uart_regs_pkg::*;
#(
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1,
    parameter int DL_W       = 16
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [7:0]        wb_dat_i,
    output logic [7:0]        wb_dat_o,
    input  logic              wb_we_i,
    input  logic              wb_re_i,
    output logic              tf_push_o,
    input  logic [CNT_W-1:0]  tf_count_i,
    input  logic              tx_idle_i,
    output logic              rf_pop_o,
    input  logic [10:0]       rf_data_i,
    input  logic [CNT_W-1:0]  rf_count_i,
    input  logic              rf_overrun_i,
    input  logic              rf_error_i,
    input  logic              rx_timeout_i,
    input  logic [3:0]        modem_inputs,
    output logic              rts_pad_o,
    output logic              dtr_pad_o,
    output logic [7:0]        lcr_o,
    output logic              enable_o,
    output logic              rx_reset_o,
    output logic              tx_reset_o,
    output logic              int_o
);

    localparam bit HAS_DL3 = (DL_W > 16);
`ifdef UART_FRAC_DIV_EN
    localparam bit FRAC = 1'b1;
    logic [3:0] dlf;
`else
    localparam bit FRAC = 1'b0;
`endif

    logic [2:0]  a;
    logic        dlab;
    logic [7:0]  lcr, scr;
    logic [3:0]  ier;
    logic [1:0]  fcr;
    logic [4:0]  mcr;
    logic [23:0] dl_r, dl_nx;
    logic        dl0_wr, dl1_wr, dl2_wr, dl_wr, dlf_wr;
    logic        thr_wr, ier_wr, fcr_wr, lcr_wr, mcr_wr, scr_wr;
    logic        rb_rd, iir_rd, lsr_rd, msr_rd;
    logic        thr_wr_q, fcr_wr_q, rb_rd_q, lsr_rd_q, msr_rd_q;
    logic        hv, tf_empty, lsr5_q, thre_pend, ti_pend;
    logic [4:0]  st, st_raw, st_raw_q;
    logic [7:0]  lsr, rd_data;
    logic [3:0]  msr_hi, msr_dl, msr_in;
    logic        msr_init;
    logic [3:0]  iir, iir_nx;
    logic        int_nx;
    logic [CNT_W-1:0] trig;

    assign a    = wb_addr_i[2:0];
    assign dlab = lcr[LCR_DLAB];

    assign thr_wr = wb_we_i && a == A_RB && !dlab;
    assign dl0_wr = wb_we_i && a == A_RB && dlab;
    assign ier_wr = wb_we_i && a == A_IER && !dlab;
    assign dl1_wr = wb_we_i && a == A_IER && dlab;
    assign dl2_wr = wb_we_i && a == A_IIR && dlab && HAS_DL3;
    assign fcr_wr = wb_we_i && a == A_IIR && !(dlab && HAS_DL3);
    assign lcr_wr = wb_we_i && a == A_LCR;
    assign mcr_wr = wb_we_i && a == A_MCR;
    assign dlf_wr = wb_we_i && a == A_SCR && dlab && FRAC;
    assign scr_wr = wb_we_i && a == A_SCR && !(dlab && FRAC);
    assign dl_wr  = dl0_wr || dl1_wr || dl2_wr;

    assign rb_rd  = wb_re_i && a == A_RB && !dlab;
    assign iir_rd = wb_re_i && a == A_IIR && !(dlab && HAS_DL3);
    assign lsr_rd = wb_re_i && a == A_LSR;
    assign msr_rd = wb_re_i && a == A_MSR;

    // Strobes fire only on the first cycle of a held access.
    assign tf_push_o  = thr_wr && !thr_wr_q;
    assign rf_pop_o   = rb_rd && !rb_rd_q;
    assign rx_reset_o = fcr_wr && !fcr_wr_q && wb_dat_i[1];
    assign tx_reset_o = fcr_wr && !fcr_wr_q && wb_dat_i[2];

    assign lcr_o     = lcr;
    assign rts_pad_o = mcr[1];
    assign dtr_pad_o = mcr[0];

    always_comb begin
        dl_nx = dl_r;
        if (dl0_wr) dl_nx[7:0]   = wb_dat_i;
        if (dl1_wr) dl_nx[15:8]  = wb_dat_i;
        if (dl2_wr) dl_nx[23:16] = wb_dat_i;
    end

    uart_baud_gen #(.DL_W(DL_W)) u_baud (
        .clk    (clk),
        .rst    (wb_rst_i),
`ifdef UART_FRAC_DIV_EN
        .dlf    (dlf),
`endif
        .dl     (dl_nx[DL_W-1:0]),
        .reload (dl_wr),
        .enable (enable_o)
    );

    assign hv       = (rf_count_i != '0);
    assign tf_empty = (tf_count_i == '0);
    assign st_raw   = {rf_error_i, hv & rf_data_i[2], hv & rf_data_i[1],
                       hv & rf_data_i[0], rf_overrun_i};
    assign lsr      = {st[4], tf_empty & tx_idle_i, tf_empty,
                       st[3], st[2], st[1], st[0], hv};

    assign msr_in = mcr[MCR_LOOP] ? {mcr[3], mcr[2], mcr[0], mcr[1]}
                  : ~{modem_inputs[0], modem_inputs[1],
                      modem_inputs[2], modem_inputs[3]};

    assign trig = CNT_W'(rx_trigger(fcr, FIFO_DEPTH));

    always_comb begin
        rd_data = '0;
        case (a)
            A_RB:  rd_data = dlab ? dl_r[7:0] : rf_data_i[10:3];
            A_IER: rd_data = dlab ? dl_r[15:8] : {4'b0, ier};
            A_IIR: rd_data = (dlab && HAS_DL3) ? dl_r[23:16]
                                               : {4'b1100, iir};
            A_LCR: rd_data = lcr;
            A_MCR: rd_data = {3'b0, mcr};
            A_LSR: rd_data = lsr;
            A_MSR: rd_data = {msr_hi, msr_dl};
`ifdef UART_FRAC_DIV_EN
            A_SCR: rd_data = dlab ? {4'b0, dlf} : scr;
`else
            A_SCR: rd_data = scr;
`endif
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        iir_nx = IIR_NONE;
        int_nx = 1'b1;
        if (ier[IER_RLS] && |st[3:0])          iir_nx = IIR_RLS;
        else if (ier[IER_RDA] && rf_count_i >= trig) iir_nx = IIR_RDA;
        else if (ier[IER_RDA] && ti_pend)      iir_nx = IIR_TI;
        else if (ier[IER_THRE] && thre_pend)   iir_nx = IIR_THRE;
        else if (ier[IER_MS] && |msr_dl)       iir_nx = IIR_MS;
        else                                   int_nx = 1'b0;
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            lcr  <= 8'h03;
            ier  <= '0;
            fcr  <= 2'b11;
            mcr  <= '0;
            scr  <= '0;
            dl_r <= '0;
`ifdef UART_FRAC_DIV_EN
            dlf  <= '0;
`endif
        end else begin
            if (lcr_wr) lcr <= wb_dat_i;
            if (ier_wr) ier <= wb_dat_i[3:0];
            if (fcr_wr) fcr <= wb_dat_i[7:6];
            if (mcr_wr) mcr <= wb_dat_i[4:0];
            if (scr_wr) scr <= wb_dat_i;
            dl_r <= dl_nx;
`ifdef UART_FRAC_DIV_EN
            if (dlf_wr) dlf <= wb_dat_i[3:0];
`endif
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_dat_o <= '0;
            thr_wr_q <= 1'b0;
            fcr_wr_q <= 1'b0;
            rb_rd_q  <= 1'b0;
            lsr_rd_q <= 1'b0;
            msr_rd_q <= 1'b0;
        end else begin
            wb_dat_o <= wb_re_i ? rd_data : '0;
            thr_wr_q <= thr_wr;
            fcr_wr_q <= fcr_wr;
            rb_rd_q  <= rb_rd;
            lsr_rd_q <= lsr_rd;
            msr_rd_q <= msr_rd;
        end
    end

    // Sticky line status captures rising edges so a persisting head
    // flag does not re-arm immediately after an LSR read clears it.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            st        <= '0;
            st_raw_q  <= '0;
            lsr5_q    <= 1'b1;
            thre_pend <= 1'b0;
            ti_pend   <= 1'b0;
        end else begin
            st_raw_q <= st_raw;
            lsr5_q   <= tf_empty;
            st <= ((lsr_rd && !lsr_rd_q) ? 5'b0 : st)
                | (st_raw & ~st_raw_q);
            if (tf_empty && !lsr5_q)
                thre_pend <= 1'b1;
            else if (thr_wr || (iir_rd && iir == IIR_THRE))
                thre_pend <= 1'b0;
            if (ier[IER_RDA] && rx_timeout_i)
                ti_pend <= 1'b1;
            else if (rb_rd)
                ti_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            msr_hi   <= '0;
            msr_dl   <= '0;
            msr_init <= 1'b1;
        end else begin
            msr_hi   <= msr_in;
            msr_init <= 1'b0;
            if (!msr_init)
                msr_dl <= (msr_rd_q ? 4'b0 : msr_dl) | (msr_in ^ msr_hi);
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            iir   <= IIR_NONE;
            int_o <= 1'b0;
        end else begin
            iir   <= iir_nx;
            int_o <= int_nx;
        end
    end

endmodule

// File: tb/tb_uart_regs_gen.sv
// Directed self-checking bench for uart_regs_gen.
// Covers reset map, baud divisor, FIFO strobes, interrupts and loopback.
module tb_uart_regs_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  addr;
    logic [7:0]  dat, dat_o;
    logic        we, re;
    logic        tf_push, rf_pop;
    logic [4:0]  tf_count, rf_count;
    logic        tx_idle;
    logic [10:0] rf_data;
    logic        overrun, rx_err, timeout;
    logic [3:0]  modem;
    logic        rts, dtr;
    logic [7:0]  lcr;
    logic        enable, rx_rst, tx_rst, intr;
    logic [7:0]  v;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    uart_regs_gen dut (
        .clk          (clk),
        .wb_rst_i     (rst),
        .wb_addr_i    (addr),
        .wb_dat_i     (dat),
        .wb_dat_o     (dat_o),
        .wb_we_i      (we),
        .wb_re_i      (re),
        .tf_push_o    (tf_push),
        .tf_count_i   (tf_count),
        .tx_idle_i    (tx_idle),
        .rf_pop_o     (rf_pop),
        .rf_data_i    (rf_data),
        .rf_count_i   (rf_count),
        .rf_overrun_i (overrun),
        .rf_error_i   (rx_err),
        .rx_timeout_i (timeout),
        .modem_inputs (modem),
        .rts_pad_o    (rts),
        .dtr_pad_o    (dtr),
        .lcr_o        (lcr),
        .enable_o     (enable),
        .rx_reset_o   (rx_rst),
        .tx_reset_o   (tx_rst),
        .int_o        (intr)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] ad, input logic [7:0] d);
        @(negedge clk);
        addr = ad;
        dat  = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic rd(input logic [2:0] ad, output logic [7:0] d);
        @(negedge clk);
        addr = ad;
        re   = 1'b1;
        @(negedge clk);
        re   = 1'b0;
        d    = dat_o;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] ad,
                          input logic [7:0] exp);
        logic [7:0] r;
        rd(ad, r);
        check(tag, 32'(r), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; addr = '0; dat = '0; we = 1'b0; re = 1'b0;
        tf_count = '0; rf_count = '0; tx_idle = 1'b1; rf_data = '0;
        overrun = 1'b0; rx_err = 1'b0; timeout = 1'b0; modem = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_dat_o", 32'(dat_o), 32'h00);
        check("rst_int", 32'(intr), 32'h0);
        check("rst_enable", 32'(enable), 32'h0);
        check("rst_lcr_o", 32'(lcr), 32'h03);
        rd_chk("rst_lcr", 3'd3, 8'h03);
        rd_chk("rst_iir", 3'd2, 8'hC1);
        rd_chk("rst_lsr", 3'd5, 8'h60);
        rd_chk("rst_ier", 3'd1, 8'h00);
        rd_chk("rst_scr", 3'd7, 8'h00);
        rd_chk("rst_mcr", 3'd4, 8'h00);
        rd_chk("rst_msr", 3'd6, 8'h00);
        rd_chk("rst_rb", 3'd0, 8'h00);
        @(negedge clk);
        check("idle_dat_o", 32'(dat_o), 32'h00);

        // Scratch register
        wr(3'd7, 8'hA5);
        rd_chk("scr", 3'd7, 8'hA5);

        // THR push: one pulse even when the write is held
        @(negedge clk);
        addr = 3'd0; dat = 8'h77; we = 1'b1;
        #1 check("push_first", 32'(tf_push), 32'h1);
        @(negedge clk);
        #1 check("push_held", 32'(tf_push), 32'h0);
        we = 1'b0;

        // Baud divisor 3, then rewrite to 1 mid-period
        wr(3'd3, 8'h83);
        check("lcr_dlab", 32'(lcr), 32'h83);
        wr(3'd1, 8'h00);
        wr(3'd0, 8'h03);
        for (int k = 0; k < 6; k++) begin
            check("baud_dl3", 32'(enable), 32'((k % 3) == 2));
            @(negedge clk);
        end
        wr(3'd0, 8'h01);
        for (int k = 0; k < 4; k++) begin
            check("baud_dl1", 32'(enable), 32'h1);
            @(negedge clk);
        end
        rd_chk("dl_lo", 3'd0, 8'h01);
        wr(3'd3, 8'h03);

        // FCR write: reset pulses, trigger = DEPTH/4
        @(negedge clk);
        addr = 3'd2; dat = 8'h46; we = 1'b1;
        #1 check("rx_reset", 32'(rx_rst), 32'h1);
        check("tx_reset", 32'(tx_rst), 32'h1);
        @(negedge clk);
        #1 check("rx_reset_held", 32'(rx_rst), 32'h0);
        we = 1'b0;

        // RX data available at trigger level 4
        wr(3'd1, 8'h01);
        rf_count = 5'd3;
        repeat (2) @(negedge clk);
        check("rda_below", 32'(intr), 32'h0);
        rf_count = 5'd4;
        repeat (2) @(negedge clk);
        check("rda_int", 32'(intr), 32'h1);
        rd_chk("rda_iir", 3'd2, 8'hC4);

        // Held RB read gives a single pop
        rf_data = {8'h5A, 3'b000};
        @(negedge clk);
        addr = 3'd0; re = 1'b1;
        #1 check("pop_first", 32'(rf_pop), 32'h1);
        @(negedge clk);
        check("rb_data", 32'(dat_o), 32'h5A);
        #1 check("pop_held", 32'(rf_pop), 32'h0);
        @(negedge clk);
        re = 1'b0;
        rf_count = 5'd0;
        repeat (2) @(negedge clk);
        check("rda_clear", 32'(intr), 32'h0);

        // Line status vs THRE priority
        rf_data  = {8'h11, 3'b001};
        tf_count = 5'd2;
        wr(3'd1, 8'h07);
        rf_count = 5'd1;
        tf_count = 5'd0;
        repeat (2) @(negedge clk);
        check("rls_int", 32'(intr), 32'h1);
        rd_chk("rls_iir", 3'd2, 8'hC6);
        rd_chk("lsr_pe", 3'd5, 8'h65);
        rd_chk("lsr_pe_clr", 3'd5, 8'h61);
        rd_chk("thre_iir", 3'd2, 8'hC2);
        rd_chk("none_iir", 3'd2, 8'hC1);
        check("none_int", 32'(intr), 32'h0);
        rf_count = 5'd0;

        // Modem loopback
        wr(3'd4, 8'h13);
        check("rts", 32'(rts), 32'h1);
        check("dtr", 32'(dtr), 32'h1);
        rd_chk("msr_1", 3'd6, 8'h33);
        rd_chk("msr_2", 3'd6, 8'h30);

`ifdef UART_FRAC_DIV_EN
        // Fractional divisor 4 + 8/16
        wr(3'd3, 8'h83);
        wr(3'd1, 8'h00);
        wr(3'd0, 8'h04);
        wr(3'd7, 8'h08);
        n = 0;
        while (!enable && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("frac_start", 32'(enable), 32'h1);
        for (int p = 0; p < 4; p++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!enable && n < 20);
            check("frac_period", 32'(n), (p % 2) ? 32'd5 : 32'd4);
        end
        wr(3'd3, 8'h03);
`endif

        // Asynchronous reset mid-count
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("arst_enable", 32'(enable), 32'h0);
        check("arst_lcr", 32'(lcr), 32'h03);
        check("arst_int", 32'(intr), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("arst_enable_hold", 32'(enable), 32'h0);
        rd_chk("arst_scr", 3'd7, 8'h00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_regs_gen.md
# uart_regs_gen

Parametrised next-generation UART register file, baud generator and interrupt prioritiser for the Wishbone UART core. Decodes the 16550-style register map, drives push/pop strobes to external TX/RX FIFOs, produces the ×16 baud enable, and raises a single prioritised interrupt. Generalises FIFO depth, address width and divisor width, and adds a fractional divisor option.

## Interface
- ADDR_W, 3: Wishbone address width. Only the low 3 bits are decoded.
- FIFO_DEPTH, 16: depth of the external FIFOs. Power of 2, ≥4.
- CNT_W, $clog2(FIFO_DEPTH)+1: FIFO count width.
- DL_W, 16: divisor width, 16 or 24.
- clk  in  1  system clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- wb_addr_i  in  ADDR_W  register address.
- wb_dat_i  in  8  write data.
- wb_dat_o  out  8  registered read data.
- wb_we_i / wb_re_i  in  1  write / read strobes. Never asserted together.
- tf_push_o  out  1  TX FIFO push. Data is wb_dat_i.
- tf_count_i  in  CNT_W  TX FIFO fill level.
- tx_idle_i  in  1  transmitter shift register empty.
- rf_pop_o  out  1  RX FIFO pop.
- rf_data_i  in  11  head entry: {data[7:0], BI, FE, PE}.
- rf_count_i  in  CNT_W  RX FIFO fill level.
- rf_overrun_i, rf_error_i, rx_timeout_i  in  1  receiver status pulses and levels.
- modem_inputs  in  4  {cts,dsr,ri,dcd}, active low.
- rts_pad_o, dtr_pad_o  out  1  mcr[1], mcr[0].
- lcr_o  out  8  line control register.
- enable_o  out  1  ×16 baud tick.
- rx_reset_o, tx_reset_o  out  1  FIFO clear pulses.
- int_o  out  1  interrupt.

## Operation
- Register map, DLAB = lcr[7]:
  - 0: RB read / THR write. With DLAB: DL[7:0].
  - 1: IER[3:0]. With DLAB: DL[15:8].
  - 2: IIR read / FCR write. With DLAB and DL_W=24: DL[23:16].
  - 3: LCR.
  - 4: MCR[4:0].
  - 5: LSR.
  - 6: MSR.
  - 7: SCR, 8-bit scratch. With DLAB and frac enabled: DLF[3:0].
- THR write pushes one word. tf_push_o pulses for exactly one cycle.
- RB read pops one word. rf_pop_o pulses on the first cycle of the read only; a held wb_re_i gives a single pop.
- FCR write: fcr[1:0] = wb_dat_i[7:6]. rx_reset_o = bit1 and tx_reset_o = bit2, each a one-cycle pulse.
- RX trigger level from fcr: 00 → 1, 01 → DEPTH/4, 10 → DEPTH/2, 11 → DEPTH−2.
- LSR bits:
  - 0: rf_count≠0.
  - 1: OE, sticky.
  - 2: PE, 3: FE, 4: BI — taken from the head entry, sticky.
  - 5: tf_count==0.
  - 6: tf_count==0 & tx_idle_i.
  - 7: rf_error_i, sticky.
- Sticky bits clear on the first cycle of an LSR read.
- MSR[7:4] = {dcd,ri,dsr,cts}: inverted pads, or {mcr[3],mcr[2],mcr[0],mcr[1]} when loopback (mcr[4]) is set.
- MSR[3:0] are delta bits, set on change of the corresponding bit. They clear the cycle after an MSR read; a change in that same cycle wins.
- Interrupt sources in priority order, with IIR codes:
  - RLS 0110: ier[2] & (LSR[1]|[2]|[3]|[4]).
  - RDA 0100: ier[0] & rf_count ≥ trigger.
  - TI 1100: ier[0] & rx_timeout_i. Sticky until RB read.
  - THRE 0010: ier[1] & rising edge of LSR[5]. Cleared by an IIR read that reports THRE, or by a THR write.
  - MS 0000: ier[3] & |MSR[3:0].
  - None: 0001.
- Disabling an IER bit drops its source immediately.
- IIR read returns {4'b1100, iir}.
- int_o = any source active.
- Reset values:
  - wb_dat_o 0, lcr 0x03, ier 0, fcr 2'b11, mcr 0, SCR 0.
  - DL 0, DLF 0.
  - msr[3:0] 0; msr[7:4] load from the inputs on the first cycle after reset.
  - iir 4'b0001, int_o 0, enable_o 0.
  - All strobes 0.

## Timing
- wb_dat_o is registered: valid the cycle after wb_re_i. When no read is active it returns 0.
- Writes take effect at the clock edge where wb_we_i is sampled.
- iir and int_o are registered: one cycle after the source condition.
- Baud generator, counter dlc of DL_W bits:
  - Writing any DL byte reloads dlc = DL−1.
  - On each cycle with dlc==0 and DL≠0: enable_o = 1 and dlc reloads.
  - Period = DL cycles. DL=1 gives enable_o constantly high. DL=0 holds enable_o low.
- Reset asserted mid-count clears dlc and the accumulator immediately.

## Configuration
- UART_FRAC_DIV_EN defined:
  - 4-bit DLF register and 4-bit accumulator.
  - At each terminal count: acc += DLF. A carry inserts one extra idle cycle before the next period.
  - Mean period = DL + DLF/16.
- UART_FRAC_DIV_EN undefined:
  - No DLF; address 7 is SCR regardless of DLAB.
  - Period is exactly DL.

## Structure
- Package uart_regs_pkg holds:
  - register address constants;
  - IIR codes;
  - LCR, IER, LSR and MSR bit indices;
  - the trigger-level function of FIFO_DEPTH.
- Sub-module uart_baud_gen (DL_W): divisor counter plus the optional fractional accumulator.
- Everything else is flat in uart_regs_gen.

## Test plan
- Reset: read all 8 addresses.
  - LCR = 0x03, IIR = 0xC1, LSR = 0x60, IER = 0, SCR = 0.
  - int_o = 0, enable_o = 0.
- DL = 3 → enable_o high every 3rd cycle. Rewriting DL = 1 mid-period → enable_o constantly high from the next cycle.
- With UART_FRAC_DIV_EN: DL = 4, DLF = 8 → enable periods alternate 4, 5, 4, 5.
- DEPTH = 16, fcr = 01, ier = 01: rf_count rises 3 → 4 → int_o = 1 and IIR = 0xC4. One RB read → single rf_pop_o pulse.
- ier = 0x07, THR emptied while rf_data_i PE = 1:
  - IIR = 0xC6 first.
  - After an LSR read: LSR[2] clears, IIR = 0xC2.
  - After an IIR read: IIR = 0xC1 and int_o = 0.
- Loopback: mcr = 0x13 → MSR = 0x33 after one read. A second MSR read returns 0x30.
